// File: rtl/fpga_serial_receiver_pkg.sv
// Shared definitions for the FPGA-to-FPGA serial link receiver.
// State encodings and link defaults used by the receiver and its sub-modules.
package fpga_serial_receiver_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int MIN_SYNC_STAGES    = 2;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        START_ACK = 4'd1,
        BIT_WAIT  = 4'd2,
        BIT_ACK   = 4'd3,
        FIN_WAIT  = 4'd4,
        FIN_ACK   = 4'd5,
        DONE      = 4'd6,
        ERROR     = 4'd7
    } state_t;

    function automatic logic is_ack_state(input state_t s);
        return (s == START_ACK) || (s == BIT_ACK) || (s == FIN_ACK);
    endfunction

endpackage

// File: rtl/fpga_serial_receiver_link_sync.sv
// Multi-flop synchroniser for one asynchronous link line.
// Depth is set by STAGES; cleared by the asynchronous reset.
module link_sync
    import fpga_serial_receiver_pkg::*;
#(
    parameter int STAGES = MIN_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/fpga_serial_receiver.sv
// Receiver side of the FPGA-to-FPGA serial link: four-phase handshake
// FSM that deserialises one word per frame, with frame and timeout checks.
module fpga_serial_receiver
    import fpga_serial_receiver_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_req,
    input  logic                  rx_data,
    input  logic                  rx_finish,
    output logic                  rx_ack,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic req_s;
    logic data_s;
    logic fin_s;

    link_sync #(.STAGES(SYNC_STAGES)) u_sync_req (
        .clk(clk), .reset(reset), .d(rx_req), .q(req_s)
    );
    link_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .reset(reset), .d(rx_data), .q(data_s)
    );
    link_sync #(.STAGES(SYNC_STAGES)) u_sync_fin (
        .clk(clk), .reset(reset), .d(rx_finish), .q(fin_s)
    );

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] sreg;
    logic [CW-1:0]         bit_cnt;
    logic [TW-1:0]         wait_cnt;
    logic                  timeout_hit;
    logic                  bit_full;

    assign bit_full    = (bit_cnt == CW'(DATA_WIDTH));
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (wait_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Protocol violations are tested before the normal advance.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fin_s)      state_next = ERROR;
                else if (req_s) state_next = START_ACK;
            end
            START_ACK: begin
                if (!req_s) state_next = BIT_WAIT;
            end
            BIT_WAIT: begin
                if (fin_s)      state_next = ERROR;
                else if (req_s) state_next = BIT_ACK;
            end
            BIT_ACK: begin
                if (!req_s) state_next = bit_full ? FIN_WAIT : BIT_WAIT;
            end
            FIN_WAIT: begin
                if (req_s)      state_next = ERROR;
                else if (fin_s) state_next = FIN_ACK;
            end
            FIN_ACK: begin
                if (!fin_s) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            ERROR: begin
                if (!req_s && !fin_s) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (timeout_hit && state != IDLE && state != ERROR) begin
            state_next = ERROR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg     <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            if (state == IDLE && state_next == START_ACK) begin
                sreg    <= '0;
                bit_cnt <= '0;
            end else if (state == BIT_WAIT && state_next == BIT_ACK) begin
                sreg <= {sreg[DATA_WIDTH-2:0], data_s};
                if (!bit_full) bit_cnt <= bit_cnt + 1'b1;
            end
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (!timeout_hit) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Outputs are registered from the next state so they track the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ack      <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_ack      <= is_ack_state(state_next);
            data_valid  <= (state_next == DONE);
            frame_error <= (state_next == ERROR) && (state != ERROR);
            busy        <= (state_next != IDLE);
            if (state_next == DONE) data_out <= sreg;
        end
    end

endmodule

// File: tb/tb_fpga_serial_receiver.sv
// Directed self-checking bench for fpga_serial_receiver.
// Drives a four-phase transmitter model and checks words, pulses and errors.
module tb_fpga_serial_receiver;

    logic       clk;
    logic       reset;
    logic       rx_req;
    logic       rx_data;
    logic       rx_finish;
    logic       rx_ack;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    int tests;
    int failed;

    int ack_rises;
    int dv_cnt;
    int fe_cnt;
    int idle_cnt;
    int both_cnt;
    logic ack_q;

    fpga_serial_receiver #(
        .DATA_WIDTH(8),
        .SYNC_STAGES(2),
        .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_req(rx_req),
        .rx_data(rx_data),
        .rx_finish(rx_finish),
        .rx_ack(rx_ack),
        .data_out(data_out),
        .data_valid(data_valid),
        .frame_error(frame_error),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        ack_rises = 0;
        dv_cnt    = 0;
        fe_cnt    = 0;
        idle_cnt  = 0;
        both_cnt  = 0;
        ack_q     = 1'b0;
    end

    always @(negedge clk) begin
        if (rx_ack === 1'b1 && ack_q !== 1'b1) ack_rises++;
        ack_q = rx_ack;
        if (data_valid === 1'b1) dv_cnt++;
        if (frame_error === 1'b1) fe_cnt++;
        if (busy === 1'b0) idle_cnt++;
        if (data_valid === 1'b1 && frame_error === 1'b1) both_cnt++;
    end

    task automatic wait_ack(input logic level, output int cyc);
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (rx_ack === level) return;
        end
        tests++;
        failed++;
        $display("FAIL ack_wait: rx_ack=%b after %0d cycles, required %b",
                 rx_ack, cyc, level);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_start();
        int c;
        rx_req = 1'b1;
        wait_ack(1'b1, c);
        rx_req = 1'b0;
        wait_ack(1'b0, c);
    endtask

    task automatic send_bit(input logic b);
        int c;
        rx_data = b;
        @(negedge clk);
        rx_req = 1'b1;
        wait_ack(1'b1, c);
        rx_req = 1'b0;
        wait_ack(1'b0, c);
    endtask

    task automatic send_finish();
        int c;
        rx_finish = 1'b1;
        wait_ack(1'b1, c);
        rx_finish = 1'b0;
        wait_ack(1'b0, c);
    endtask

    task automatic send_frame(input logic [7:0] w);
        send_start();
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        send_finish();
    endtask

    task automatic check_zero_outputs(input string tag);
        tests++;
        if (rx_ack !== 1'b0 || data_valid !== 1'b0 ||
            frame_error !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL %s_ctrl: ack=%b dv=%b fe=%b busy=%b, required all 0",
                     tag, rx_ack, data_valid, frame_error, busy);
        end
        tests++;
        if (data_out !== 8'h00) begin
            failed++;
            $display("FAIL %s_data: data_out=%h, required 00", tag, data_out);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        rx_req    = 1'b0;
        rx_data   = 1'b0;
        rx_finish = 1'b0;
        idle_cycles(3);
        check_zero_outputs("reset");
        reset = 1'b0;
        idle_cycles(3);
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_single_frame();
        int a0, d0, f0, lat;
        a0 = ack_rises;
        d0 = dv_cnt;
        f0 = fe_cnt;
        rx_req = 1'b1;
        wait_ack(1'b1, lat);
        tests++;
        if (lat != 3) begin
            failed++;
            $display("FAIL ack_rise_latency: %0d cycles, required 3", lat);
        end
        rx_req = 1'b0;
        wait_ack(1'b0, lat);
        tests++;
        if (lat != 3) begin
            failed++;
            $display("FAIL ack_fall_latency: %0d cycles, required 3", lat);
        end
        for (int i = 7; i >= 0; i--) send_bit(1'(8'hA5 >> i));
        send_finish();
        idle_cycles(3);
        tests++;
        if (ack_rises - a0 != 10) begin
            failed++;
            $display("FAIL a5_acks: %0d handshakes, required 10", ack_rises - a0);
        end
        tests++;
        if (data_out !== 8'hA5) begin
            failed++;
            $display("FAIL a5_data: data_out=%h, required a5", data_out);
        end
        tests++;
        if (dv_cnt - d0 != 1) begin
            failed++;
            $display("FAIL a5_valid: %0d pulses, required 1", dv_cnt - d0);
        end
        tests++;
        if (fe_cnt - f0 != 0) begin
            failed++;
            $display("FAIL a5_error: %0d error pulses, required 0", fe_cnt - f0);
        end
    endtask

    task automatic test_back_to_back();
        int d0, i0;
        d0 = dv_cnt;
        send_frame(8'h00);
        i0 = idle_cnt;
        idle_cycles(1);
        tests++;
        if (data_out !== 8'h00) begin
            failed++;
            $display("FAIL b2b_first: data_out=%h, required 00", data_out);
        end
        send_frame(8'hFF);
        tests++;
        if (idle_cnt - i0 < 1) begin
            failed++;
            $display("FAIL b2b_gap: busy low %0d cycles, required >=1",
                     idle_cnt - i0);
        end
        idle_cycles(3);
        tests++;
        if (dv_cnt - d0 != 2) begin
            failed++;
            $display("FAIL b2b_valid: %0d pulses, required 2", dv_cnt - d0);
        end
        tests++;
        if (data_out !== 8'hFF) begin
            failed++;
            $display("FAIL b2b_data: data_out=%h, required ff", data_out);
        end
    endtask

    task automatic test_short_frame();
        int a0, f0, d0;
        send_start();
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        a0 = ack_rises;
        f0 = fe_cnt;
        d0 = dv_cnt;
        rx_finish = 1'b1;
        idle_cycles(20);
        tests++;
        if (ack_rises - a0 != 0 || rx_ack !== 1'b0) begin
            failed++;
            $display("FAIL short_ack: %0d ack rises, ack=%b, required 0",
                     ack_rises - a0, rx_ack);
        end
        tests++;
        if (fe_cnt - f0 != 1) begin
            failed++;
            $display("FAIL short_error: %0d pulses, required 1", fe_cnt - f0);
        end
        tests++;
        if (busy !== 1'b1) begin
            failed++;
            $display("FAIL short_hold: busy=%b, required 1", busy);
        end
        rx_finish = 1'b0;
        idle_cycles(6);
        tests++;
        if (busy !== 1'b0 || dv_cnt - d0 != 0) begin
            failed++;
            $display("FAIL short_recover: busy=%b dv=%0d, required 0/0",
                     busy, dv_cnt - d0);
        end
        tests++;
        if (data_out !== 8'hFF) begin
            failed++;
            $display("FAIL short_data: data_out=%h, required ff", data_out);
        end
    endtask

    task automatic test_timeout();
        int c, n, f0;
        bit seen;
        f0 = fe_cnt;
        rx_req = 1'b1;
        wait_ack(1'b1, c);
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 1200 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (frame_error === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen || n < 1024 || n > 1026) begin
            failed++;
            $display("FAIL timeout_at: seen=%0d after %0d cycles, required ~1025",
                     seen, n);
        end
        idle_cycles(1100 - n - c);
        tests++;
        if (busy !== 1'b1 || rx_ack !== 1'b0 || fe_cnt - f0 != 1) begin
            failed++;
            $display("FAIL timeout_hold: busy=%b ack=%b fe=%0d, required 1/0/1",
                     busy, rx_ack, fe_cnt - f0);
        end
        rx_req = 1'b0;
        idle_cycles(6);
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL timeout_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int c, d0;
        send_start();
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rx_data = 1'b1;
        @(negedge clk);
        rx_req = 1'b1;
        wait_ack(1'b1, c);
        #2;
        reset = 1'b1;
        #1;
        check_zero_outputs("midreset");
        rx_req  = 1'b0;
        rx_data = 1'b0;
        idle_cycles(3);
        reset = 1'b0;
        idle_cycles(3);
        d0 = dv_cnt;
        send_frame(8'h3C);
        idle_cycles(3);
        tests++;
        if (data_out !== 8'h3C || dv_cnt - d0 != 1) begin
            failed++;
            $display("FAIL post_reset_frame: data_out=%h dv=%0d, required 3c/1",
                     data_out, dv_cnt - d0);
        end
    endtask

    task automatic test_long_frame();
        int a0, f0, d0;
        send_start();
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        a0 = ack_rises;
        f0 = fe_cnt;
        d0 = dv_cnt;
        rx_data = 1'b0;
        @(negedge clk);
        rx_req = 1'b1;
        idle_cycles(10);
        tests++;
        if (fe_cnt - f0 != 1 || ack_rises - a0 != 0) begin
            failed++;
            $display("FAIL long_error: fe=%0d acks=%0d, required 1/0",
                     fe_cnt - f0, ack_rises - a0);
        end
        rx_req = 1'b0;
        idle_cycles(6);
        tests++;
        if (dv_cnt - d0 != 0 || data_out !== 8'h3C || busy !== 1'b0) begin
            failed++;
            $display("FAIL long_keep: dv=%0d data_out=%h busy=%b, required 0/3c/0",
                     dv_cnt - d0, data_out, busy);
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_short_frame();
        test_timeout();
        test_reset_mid_frame();
        test_long_frame();
        tests++;
        if (both_cnt != 0) begin
            failed++;
            $display("FAIL exclusive_pulses: %0d overlaps, required 0", both_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
